reg_load_ctrl: RTL and testbench
================================

// Module: reg_load_ctrl
// PURPOSE
//   Front-end load controller for the 8-bit enable/reset data register.
//   Synchronises board switches and two push-buttons (LOAD, CLEAR), debounces them,
//   and issues single-cycle, mutually exclusive load-enable / clear strobes plus the data byte.
//   Sits directly upstream of the register: d_out->d, enable_out->enable, clear_out->reset.
// PARAMETERS
//   WIDTH        8       data width of sw / d_out
//   SYNC_STAGES  2       flip-flop stages on every async input (min 2)
//   DB_CYCLES    500000  cycles a button level must be stable to be accepted (10 ms @ 50 MHz; min 2)
// PORTS
//   clk         in   1      system clock, all logic on posedge
//   reset       in   1      asynchronous, active-high reset
//   sw          in   WIDTH  raw switch value (async)
//   btn_load    in   1      raw LOAD button, active high (async)
//   btn_clr     in   1      raw CLEAR button, active high (async)
//   d_out       out  WIDTH  byte presented to register d
//   enable_out  out  1      one-cycle load strobe
//   clear_out   out  1      one-cycle clear strobe
//   busy        out  1      high whenever FSM is not IDLE
// BEHAVIOUR
//   - Reset (async, active-high): all sync flops 0, counter 0, FSM=IDLE, d_out=0, enable_out=0,
//     clear_out=0, busy=0. Reset mid-operation aborts any debounce; no strobe issued.
//   - sw, btn_load, btn_clr each pass through SYNC_STAGES flops -> sw_s, ld_s, cl_s.
//   - Debounce counter width $clog2(DB_CYCLES+1); FSM states:
//     IDLE:   ld_s|cl_s -> PRESS_DB, cnt=0, sel=CLR if cl_s else LOAD (CLEAR wins ties).
//     PRESS_DB: selected sync button high -> cnt++; cnt==DB_CYCLES-1 -> FIRE.
//               selected button low before that -> IDLE (glitch rejected, no strobe).
//               the other button is ignored while in PRESS_DB.
//     FIRE:   exactly one cycle. sel=LOAD: enable_out=1, d_out<=sw_s sampled this cycle.
//             sel=CLR: clear_out=1, d_out<=0. Next -> RELEASE_DB, cnt=0.
//     RELEASE_DB: both ld_s and cl_s low -> cnt++; cnt==DB_CYCLES-1 -> IDLE.
//                 either high -> cnt=0 (bounce on release restarts wait; no re-fire).
//   - All outputs registered. enable_out and clear_out never high in the same cycle;
//     each is high for exactly one cycle per accepted press; holding a button never repeats.
//   - d_out holds its last value between strobes; changes only in FIRE.
//   - Latency: clean press -> strobe on the SYNC_STAGES+DB_CYCLES+1-th rising edge
//     after the first edge sampling the button high (+/-1 for async sampling).
//   - busy=1 in PRESS_DB, FIRE, RELEASE_DB.
// CONFIGURATION
//   LOAD_COUNT_EN defined: extra port load_count out 8 -- count of enable_out strobes,
//     +1 on each FIRE with sel=LOAD, wraps 255->0, cleared only by reset (not clear_out).
//   LOAD_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (DB_CYCLES=4, SYNC_STAGES=2)
//   1 reset high mid-PRESS_DB with btn_load=1 -> outputs 0, busy 0 next edge; no strobe after release of reset until new debounce completes.
//   2 sw=8'hA5, clean btn_load held 20 cycles -> single enable_out pulse, d_out=8'hA5 at edge 7, busy until btn low +4 cycles.
//   3 btn_load high 2 cycles then low -> no enable_out, d_out unchanged, FSM back to IDLE.
//   4 btn_load and btn_clr rise same cycle -> clear_out one pulse, d_out=0, enable_out never high.
//   5 release bounce (low 2, high 1, low 10) after accepted press -> no second strobe; IDLE 4 cycles after final low.
//   6 LOAD_COUNT_EN: 257 accepted loads -> load_count=1; clear presses leave it unchanged.

Source files
------------

// File: rtl/reg_load_ctrl.sv
// reg_load_ctrl: front-end for the 8-bit enable/reset data register.
// Synchronises the switches and the LOAD/CLEAR buttons, debounces the buttons,
// and emits one-cycle, mutually exclusive load/clear strobes with the data byte.
// Optional feature macro: LOAD_COUNT_EN adds the 8-bit load_count output.
//
// state      | meaning
// IDLE       | waiting for either synchronised button
// PRESS_DB   | selected button must stay high DB_CYCLES cycles
// FIRE       | strobe cycle (enable_out or clear_out high)
// RELEASE_DB | both buttons must stay low DB_CYCLES cycles
module reg_load_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clr,
  output logic [WIDTH-1:0] d_out,
  output logic             enable_out,
  output logic             clear_out,
  output logic             busy
`ifdef LOAD_COUNT_EN
  ,
  output logic [7:0]       load_count
`endif
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  // Debounce timer counts down from DB_CYCLES-1 to zero.
  localparam logic [CW-1:0] CNT_LOAD = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    FIRE       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sw_sync_q;
  logic [SYNC_STAGES-1:0]            ld_sync_q;
  logic [SYNC_STAGES-1:0]            cl_sync_q;
  logic [WIDTH-1:0]                  sw_s;
  logic                              ld_s;
  logic                              cl_s;
  logic                              sel_btn;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel_clr_q, sel_clr_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic             en_q, en_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;

  assign sw_s    = sw_sync_q[SYNC_STAGES-1];
  assign ld_s    = ld_sync_q[SYNC_STAGES-1];
  assign cl_s    = cl_sync_q[SYNC_STAGES-1];
  assign sel_btn = sel_clr_q ? cl_s : ld_s;

  // Synchroniser chains for every asynchronous input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync_q <= '0;
      ld_sync_q <= '0;
      cl_sync_q <= '0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw};
      ld_sync_q <= {ld_sync_q[SYNC_STAGES-2:0], btn_load};
      cl_sync_q <= {cl_sync_q[SYNC_STAGES-2:0], btn_clr};
    end
  end

  // Next-state, debounce timer and registered-output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_clr_d = sel_clr_q;
    d_out_d   = d_out_q;
    en_d      = 1'b0;
    clr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_s || cl_s) begin
          state_d   = PRESS_DB;
          cnt_d     = CNT_LOAD;
          sel_clr_d = cl_s;  // CLEAR wins a simultaneous press
        end
      end
      PRESS_DB: begin
        if (!sel_btn) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          // Strobes are registered so they appear for the single FIRE cycle.
          state_d = FIRE;
          if (sel_clr_q) begin
            clr_d   = 1'b1;
            d_out_d = '0;
          end else begin
            en_d    = 1'b1;
            d_out_d = sw_s;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIRE: begin
        state_d = RELEASE_DB;
        cnt_d   = CNT_LOAD;
      end
      RELEASE_DB: begin
        if (ld_s || cl_s) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_clr_q <= 1'b0;
      d_out_q   <= '0;
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_clr_q <= sel_clr_d;
      d_out_q   <= d_out_d;
      en_q      <= en_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
    end
  end

  assign d_out      = d_out_q;
  assign enable_out = en_q;
  assign clear_out  = clr_q;
  assign busy       = busy_q;

`ifdef LOAD_COUNT_EN
  logic [7:0] load_cnt_q;

  // Count of load strobes; only reset clears it, wraps naturally at 8 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt_q <= '0;
    end else if (en_d) begin
      load_cnt_q <= load_cnt_q + 8'd1;
    end
  end

  assign load_count = load_cnt_q;
`endif

endmodule

// File: tb/tb_reg_load_ctrl.sv
// Scoreboard bench for reg_load_ctrl (WIDTH=8, SYNC_STAGES=2, DB_CYCLES=4).
module tb_reg_load_ctrl;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LAT  = SYNC + DB + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic       btn_load;
  logic       btn_clr;
  logic [7:0] d_out;
  logic       enable_out;
  logic       clear_out;
  logic       busy;
`ifdef LOAD_COUNT_EN
  logic [7:0] load_count;
`endif

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int n_loads     = 0;

  typedef struct {
    bit         is_clr;
    logic [7:0] d;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] d_hold = 8'h00;

  reg_load_ctrl #(.WIDTH(8), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .btn_load   (btn_load),
    .btn_clr    (btn_clr),
    .d_out      (d_out),
    .enable_out (enable_out),
    .clear_out  (clear_out),
    .busy       (busy)
`ifdef LOAD_COUNT_EN
    ,
    .load_count (load_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops the expected strobe whenever the DUT presents one
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        d_hold = 8'h00;
      end else begin
        check("strobe_exclusive", int'(enable_out & clear_out), 0);
        if (enable_out || clear_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", int'(enable_out | clear_out), 0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_kind_clr", int'(clear_out), int'(e.is_clr));
            check("strobe_data", int'(d_out), int'(e.d));
            check("strobe_cycle", cyc, e.at);
            d_hold = e.d;
          end
        end else begin
          check("d_out_hold", int'(d_out), int'(d_hold));
        end
      end
    end
  end

  // mode: 0 load, 1 clear, 2 both same cycle, 3 load with a short clear glitch
  task automatic press(int mode, int h, bit bounce, logic [7:0] v);
    int   n, m, f, idle, total;
    bit   acc, lvl, is_clr;
    exp_t e;
    @(negedge clk);
    sw = v;
    @(negedge clk);
    n      = cyc;
    acc    = (h >= DB + 1);
    is_clr = (mode == 1) || (mode == 2);
    if (!acc) bounce = 1'b0;
    m    = n + h + (bounce ? 3 : 0);
    f    = n + LAT;
    idle = acc ? (((f + 1) > (m + SYNC)) ? (f + 1) : (m + SYNC)) + DB
               : n + h + SYNC + 1;
    if (acc) begin
      e.is_clr = is_clr;
      e.d      = is_clr ? 8'h00 : v;
      e.at     = f;
      exp_q.push_back(e);
      if (!is_clr) n_loads++;
    end
    total = m - n + 16;
    for (int k = 0; k < total; k++) begin
      lvl      = (k < h) || (bounce && (k == h + 2));
      btn_load = lvl && (mode != 1);
      btn_clr  = (lvl && is_clr) || ((mode == 3) && (k == 1 || k == 2));
      if (n + k == idle - 1) check("busy_before_idle", int'(busy), 1);
      if (n + k == idle)     check("busy_at_idle", int'(busy), 0);
      @(negedge clk);
    end
  endtask

  task automatic reset_mid_press();
    int   r;
    exp_t e;
    @(negedge clk);
    sw       = 8'h3C;
    btn_load = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_in_press", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_enable", int'(enable_out), 0);
    check("rst_clear", int'(clear_out), 0);
    check("rst_d_out", int'(d_out), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    r     = cyc;
    e.is_clr = 1'b0;
    e.d      = 8'h3C;
    e.at     = r + LAT;
    exp_q.push_back(e);
    n_loads++;
    repeat (12) @(negedge clk);
    btn_load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (r + 12 + k == r + 17) check("rst_busy_before_idle", int'(busy), 1);
      if (r + 12 + k == r + 18) check("rst_busy_at_idle", int'(busy), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    int mode, h;
    reset    = 1'b1;
    sw       = 8'h00;
    btn_load = 1'b0;
    btn_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("init_enable", int'(enable_out), 0);
    check("init_clear", int'(clear_out), 0);
    check("init_d_out", int'(d_out), 0);
    check("init_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    press(0, 20, 1'b0, 8'hA5);
    reset_mid_press();
    press(0, 2, 1'b0, 8'h5A);
    press(2, 10, 1'b0, 8'hFF);
    press(0, 9, 1'b1, 8'h81);
    press(1, 8, 1'b1, 8'h42);
    press(0, 4, 1'b0, 8'h11);
    press(0, 5, 1'b0, 8'h22);
    press(1, 4, 1'b0, 8'h33);
    press(1, 5, 1'b1, 8'h44);
    press(3, 12, 1'b0, 8'h99);

    for (int i = 0; i < 60; i++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 3)                 h = int'($urandom_range(8, 16));
      else if ($urandom_range(0, 1)) h = int'($urandom_range(1, 4));
      else                           h = int'($urandom_range(5, 20));
      press(mode, h, 1'($urandom_range(0, 1)), 8'($urandom));
    end

`ifdef LOAD_COUNT_EN
    for (int i = 0; i < 257; i++) begin
      press(0, 5, 1'b0, 8'($urandom));
      if (i % 64 == 0) press(1, 6, 1'b0, 8'($urandom));
    end
    check("load_count", int'(load_count), n_loads % 256);
`endif

    repeat (5) @(negedge clk);
    check("missing_strobes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
